// File: rtl/gascon_perm_sequencer_pkg.sv
// Shared types and helpers for the GASCON permutation sequencer and its round core.
package gascon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        START,
        WAIT,
        OUT,
        ERR
    } seq_state_t;

    localparam int GASCON_MAX_ROUNDS = 12;

    // Round constant consumed by the core: high nibble counts down while the low nibble counts up.
    function automatic logic [7:0] round_const(input logic [3:0] rnd);
        return {4'hF - rnd, rnd};
    endfunction

endpackage

// File: rtl/gascon_perm_sequencer_if.sv
// Input/output state handshakes between the sponge logic and the permutation sequencer.
interface gascon_perm_sequencer_if #(
    parameter int CWIDTH = 320
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CWIDTH-1:0] in_state;
    logic              out_valid;
    logic              out_ready;
    logic [CWIDTH-1:0] out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/gascon_seq_timeout.sv
// Loadable wait counter that flags when it has sat at the TIMEOUT value.
module gascon_seq_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] wait_cnt_q, wait_cnt_d;

    // Saturating so a long stall can never wrap back below the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (inc && (wait_cnt_q != W'(TIMEOUT))) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired = (wait_cnt_q == W'(TIMEOUT));

endmodule

// File: rtl/gascon_perm_sequencer.sv
// Drives gascon_core_round through NUM_ROUNDS single-round passes per accepted state.
// Optional macro GASCON_SEQ_PERF_CNT_EN adds the perf_cycles latency counter.
module gascon_perm_sequencer
    import gascon_pkg::*;
#(
    parameter int CWIDTH      = 320,
    parameter int ROUND_COUNT = 16,
    parameter int NUM_ROUNDS  = 12,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gascon_perm_sequencer_if.slave bus,
    output logic                   busy,
    output logic                   error,
    output logic [CWIDTH-1:0]      core_c,
    output logic [ROUND_COUNT-1:0] core_round,
    output logic                   core_en,
    output logic                   core_rst,
    input  logic [CWIDTH-1:0]      core_cout,
    input  logic                   core_done
`ifdef GASCON_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam logic [3:0] FIRST = 4'(GASCON_MAX_ROUNDS - NUM_ROUNDS);
    localparam logic [3:0] LAST  = 4'(GASCON_MAX_ROUNDS - 1);

    seq_state_t        state_q, state_d;
    logic [CWIDTH-1:0] state_reg_q, state_reg_d;
    logic [3:0]        rnd_q, rnd_d;
    logic              error_q, error_d;
    logic              in_ready_q, out_valid_q, busy_q, core_rst_q, core_en_q;
    logic              accept, timeout_hit;

    assign accept = (state_q == IDLE) && bus.in_valid && in_ready_q;

    gascon_seq_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state_q == START),
        .inc    (state_q == WAIT),
        .expired(timeout_hit)
    );

    // A core_done in the same cycle as the timeout wins, so a late core still completes.
    always_comb begin
        state_d     = state_q;
        state_reg_d = state_reg_q;
        rnd_d       = rnd_q;
        error_d     = error_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_reg_d = bus.in_state;
                    rnd_d       = FIRST;
                    state_d     = KICK;
                end
            end
            KICK:  state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (core_done) begin
                    state_reg_d = core_cout;
                    if (rnd_q == LAST) begin
                        state_d = OUT;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = KICK;
                    end
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and core controls are decoded from the next state so they are glitch-free flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            state_reg_q <= '0;
            rnd_q       <= '0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            state_reg_q <= state_reg_d;
            rnd_q       <= rnd_d;
            error_q     <= error_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == OUT);
            busy_q      <= (state_d inside {KICK, START, WAIT, OUT});
            core_rst_q  <= !(state_d inside {START, WAIT});
            core_en_q   <= (state_d inside {START, WAIT});
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = state_reg_q;
    assign busy          = busy_q;
    assign error         = error_q;
    assign core_c        = state_reg_q;
    assign core_round    = ROUND_COUNT'(rnd_q);
    assign core_en       = core_en_q;
    assign core_rst      = core_rst_q;

`ifdef GASCON_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // The accept cycle itself counts, so the value covers accept through the last core round.
    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = 32'd1;
        end else if ((state_q inside {KICK, START, WAIT}) && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
